// File: rtl/uart_cmd_wrapper.sv
// UART command front end: receives two bytes into a 16-bit command (high byte first)
// and transmits single response bytes; receive and transmit run independently.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] C_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_baud;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_byte_done;

  asm_state_t    r_asm_state;
  logic [15:0]   r_cmd;
  logic          r_cmd_rdy;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic          r_tx;
  logic          r_tx_done;

  logic          w_rx_fall;
  logic          w_rx_tick;
  logic          w_tx_tick;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_tick = (r_rx_baud == '0);
  assign w_tx_tick = (r_tx_baud == '0);

  assign TX      = r_tx;
  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign tx_done = r_tx_done;

  // RX is asynchronous to clk; the third flop only feeds falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_baud   <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= RX_START;
            r_rx_baud  <= C_HALF;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_rx_baud  <= C_FULL;
              r_rx_bit   <= '0;
            end
          end else begin
            r_rx_baud <= r_rx_baud - 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_baud  <= C_FULL;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_baud <= r_rx_baud - 1'b1;
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            r_rx_state  <= RX_IDLE;
            r_byte_done <= r_rx_sync;
          end else begin
            r_rx_baud <= r_rx_baud - 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Set on a completed low byte takes priority over a coincident consumer clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_state <= WAIT_HIGH;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
    end else if (r_byte_done) begin
      case (r_asm_state)
        WAIT_HIGH: begin
          r_cmd[15:8] <= r_rx_shift;
          r_cmd_rdy   <= 1'b0;
          r_asm_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          r_cmd[7:0]  <= r_rx_shift;
          r_cmd_rdy   <= 1'b1;
          r_asm_state <= WAIT_HIGH;
        end
        default: r_asm_state <= WAIT_HIGH;
      endcase
    end else if (clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
    end
  end

  // Shift register holds the data bits plus the stop bit; ones fill in behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (trmt) begin
            r_tx_state <= TX_BUSY;
            r_tx_shift <= {1'b1, resp};
            r_tx_baud  <= C_FULL;
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
            r_tx_done  <= 1'b0;
          end
        end
        TX_BUSY: begin
          if (w_tx_tick) begin
            if (r_tx_bit == 4'd9) begin
              r_tx_state <= TX_IDLE;
              r_tx_done  <= 1'b1;
              r_tx       <= 1'b1;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_baud  <= C_FULL;
            end
          end else begin
            r_tx_baud <= r_tx_baud - 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
